// File: rtl/mioc_pkg.sv
// Shared types and constants for the MIOC DRAM strobe sequencer.
// Holds FSM states, BANK_SEL encodings and strobe reset levels.
package mioc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ROW,
    COL,
    ACTIVE,
    RFSH,
    PRECHARGE
  } dram_state_t;

  localparam logic [1:0] BANK_NONE = 2'b00;
  localparam logic [1:0] BANK_1    = 2'b01;
  localparam logic [1:0] BANK_2    = 2'b10;

  localparam logic RAS_N_RST  = 1'b1;
  localparam logic MUX_RST    = 1'b0;
  localparam logic CAS_N_RST  = 1'b1;
  localparam logic RA7_RST    = 1'b0;
  localparam logic WAIT_N_RST = 1'b1;

  // The illegal code 11 selects no RAM, same as ROM/unmapped.
  function automatic logic [1:0] bank_norm(input logic [1:0] sel);
    return (sel == 2'b11) ? BANK_NONE : sel;
  endfunction

endpackage

// File: rtl/dram_refresh_ctr.sv
// Refresh row counter: wraps at ROWS-1 and flips tog on each wrap.
// tog drives RA7 so successive refresh sweeps cover both row halves.
module dram_refresh_ctr
  import mioc_pkg::*;
#(
  parameter int ROWS = 128
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tog
);

  localparam int W = (ROWS > 2) ? $clog2(ROWS) : 1;
  localparam logic [W-1:0] LAST = W'(ROWS - 1);

  logic [W-1:0] cnt;

  // Advance once per finished refresh; toggle the MSB on wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      tog <= RA7_RST;
    end else if (en) begin
      if (cnt == LAST) begin
        cnt <= '0;
        tog <= ~tog;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/dram_timing_gen.sv
// DRAM strobe sequencer: RAS/MUX/CAS, precharge hold-off and refresh.
// Define RA7_REFRESH_EN to build the refresh counter that drives RA7.
module dram_timing_gen
  import mioc_pkg::*;
#(
  parameter int PRECHARGE_CYCLES = 1,
  parameter int REFRESH_ROWS     = 128
) (
  input  logic       B_PHI,
  input  logic       RST,
  input  logic       BMREQ_N,
  input  logic       BRD_N,
  input  logic       N_BWR,
  input  logic       BRFSH_N,
  input  logic [1:0] BANK_SEL,
  output logic       RAS_N,
  output logic       MUX,
  output logic       CAS1_N,
  output logic       CAS2_N,
  output logic       RA7,
  output logic       WAIT_N
);

  if (PRECHARGE_CYCLES < 1 || PRECHARGE_CYCLES > 7 ||
      REFRESH_ROWS < 2 || REFRESH_ROWS > 256 ||
      (REFRESH_ROWS & (REFRESH_ROWS - 1)) != 0) begin : g_bad_params
    $error("dram_timing_gen: illegal parameter value");
  end

  localparam logic [2:0] PC_LAST = 3'(PRECHARGE_CYCLES);

  dram_state_t state_q, state_d;
  logic [1:0]  bank_q, bank_d;
  logic [1:0]  pbank_q, pbank_d;
  logic        pend_q, pend_d;
  logic        prf_q, prf_d;
  logic [2:0]  pc_q, pc_d;

  logic        req_any, req_rf, req_mem;
  logic [1:0]  bank_in;
  logic        ras_d, mux_d, cas1_d, cas2_d, wait_d;

  assign req_any = !BMREQ_N && (!BRD_N || !N_BWR || !BRFSH_N);
  assign req_rf  = req_any && !BRFSH_N;
  assign req_mem = req_any && BRFSH_N;
  assign bank_in = bank_norm(BANK_SEL);

  // Sequencer state, latched bank and pending-request latch.
  always_ff @(posedge B_PHI or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      bank_q  <= BANK_NONE;
      pbank_q <= BANK_NONE;
      pend_q  <= 1'b0;
      prf_q   <= 1'b0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      pbank_q <= pbank_d;
      pend_q  <= pend_d;
      prf_q   <= prf_d;
      pc_q    <= pc_d;
    end
  end

  // Next state; the edge leaving PRECHARGE consults only the latch.
  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    pbank_d = pbank_q;
    pend_d  = pend_q;
    prf_d   = prf_q;
    pc_d    = pc_q;
    unique case (state_q)
      IDLE: begin
        if (req_rf) begin
          state_d = RFSH;
        end else if (req_mem) begin
          state_d = ROW;
          bank_d  = bank_in;
        end
      end
      ROW: state_d = COL;
      COL: state_d = ACTIVE;
      ACTIVE, RFSH: begin
        if (BMREQ_N) begin
          state_d = PRECHARGE;
          pc_d    = '0;
        end
      end
      PRECHARGE: begin
        if (pc_q == PC_LAST) begin
          pend_d = 1'b0;
          if (pend_q) begin
            state_d = prf_q ? RFSH : ROW;
            bank_d  = pbank_q;
          end else begin
            state_d = IDLE;
          end
        end else begin
          pc_d = pc_q + 3'd1;
          if (!pend_q && req_any) begin
            pend_d  = 1'b1;
            prf_d   = req_rf;
            pbank_d = bank_in;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobe levels for the current state, registered one edge later.
  always_comb begin
    ras_d  = !(state_q inside {ROW, COL, ACTIVE, RFSH});
    mux_d  = state_q inside {COL, ACTIVE};
    cas1_d = !(state_q == ACTIVE && bank_q == BANK_1);
    cas2_d = !(state_q == ACTIVE && bank_q == BANK_2);
    wait_d = !(state_q == PRECHARGE && pend_q);
  end

  // Output registers; reset releases every strobe at once.
  always_ff @(posedge B_PHI or posedge RST) begin
    if (RST) begin
      RAS_N  <= RAS_N_RST;
      MUX    <= MUX_RST;
      CAS1_N <= CAS_N_RST;
      CAS2_N <= CAS_N_RST;
      WAIT_N <= WAIT_N_RST;
    end else begin
      RAS_N  <= ras_d;
      MUX    <= mux_d;
      CAS1_N <= cas1_d;
      CAS2_N <= cas2_d;
      WAIT_N <= wait_d;
    end
  end

`ifdef RA7_REFRESH_EN
  logic rfsh_adv;

  assign rfsh_adv = (state_q == RFSH) && BMREQ_N;

  dram_refresh_ctr #(
    .ROWS (REFRESH_ROWS)
  ) u_refresh_ctr (
    .clk (B_PHI),
    .rst (RST),
    .en  (rfsh_adv),
    .tog (RA7)
  );
`else
  assign RA7 = RA7_RST;
`endif

endmodule

// File: tb/tb_dram_timing_gen.sv
// Self-checking bench for dram_timing_gen.
// Expected strobes come from per-cycle edge intervals.
module tb_dram_timing_gen;

  localparam int P    = 2;
  localparam int ROWS = 128;
`ifdef RA7_REFRESH_EN
  localparam logic RA7_ON = 1'b1;
`else
  localparam logic RA7_ON = 1'b0;
`endif

  // kind: 0 read, 1 write, 2 read+write, 3 refresh
  typedef struct {
    int         kind;
    logic [1:0] bank;
    int         hold;
  } cyc_t;

  logic       B_PHI, RST;
  logic       BMREQ_N, BRD_N, N_BWR, BRFSH_N;
  logic [1:0] BANK_SEL;
  logic       RAS_N, MUX, CAS1_N, CAS2_N, RA7, WAIT_N;

  int   checks, failures, cyc, rcount;
  cyc_t ca, cb;

  dram_timing_gen #(
    .PRECHARGE_CYCLES (P),
    .REFRESH_ROWS     (ROWS)
  ) dut (
    .B_PHI    (B_PHI),
    .RST      (RST),
    .BMREQ_N  (BMREQ_N),
    .BRD_N    (BRD_N),
    .N_BWR    (N_BWR),
    .BRFSH_N  (BRFSH_N),
    .BANK_SEL (BANK_SEL),
    .RAS_N    (RAS_N),
    .MUX      (MUX),
    .CAS1_N   (CAS1_N),
    .CAS2_N   (CAS2_N),
    .RA7      (RA7),
    .WAIT_N   (WAIT_N)
  );

  initial B_PHI = 1'b0;
  always #5 B_PHI = ~B_PHI;

  function automatic int imax(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

  function automatic bit is_mem(input cyc_t c);
    return c.kind != 3;
  endfunction

  function automatic int need(input cyc_t c);
    return is_mem(c) ? 3 : 1;
  endfunction

  function automatic bit inr(input int k, input int lo, input int hi);
    return (k >= lo) && (k <= hi);
  endfunction

  function automatic logic ra7_exp();
    return RA7_ON & 1'((rcount / ROWS) % 2);
  endfunction

  function automatic logic [5:0] obs();
    return {RAS_N, MUX, CAS1_N, CAS2_N, RA7, WAIT_N};
  endfunction

  function automatic bit cas_on(input cyc_t c, input logic [1:0] bk,
                                input int k, input int e0, input int n);
    return is_mem(c) && (c.bank == bk) && inr(k, e0 + 3, n);
  endfunction

  function automatic cyc_t rnd_cyc();
    cyc_t c;
    c.kind = $urandom_range(0, 3);
    c.bank = 2'($urandom);
    c.hold = $urandom_range(1, 6);
    return c;
  endfunction

  task automatic chk(input string tag, input logic [5:0] o,
                     input logic [5:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s edge=%0d observed=%b expected=%b", tag, cyc, o, e);
    end
  endtask

  task automatic step();
    @(posedge B_PHI);
    #1;
    cyc++;
  endtask

  task automatic drive_idle();
    BMREQ_N  = 1'b1;
    BRD_N    = 1'b1;
    N_BWR    = 1'b1;
    BRFSH_N  = 1'b1;
    BANK_SEL = 2'($urandom);
  endtask

  task automatic drive_req(input cyc_t c, input bit latch);
    BMREQ_N  = 1'b0;
    BRD_N    = !(c.kind == 0 || c.kind == 2);
    N_BWR    = !(c.kind == 1 || c.kind == 2);
    BRFSH_N  = (c.kind != 3);
    BANK_SEL = latch ? c.bank : 2'($urandom);
  endtask

  task automatic idle_steps(input int n, input string tag);
    repeat (n) begin
      drive_idle();
      step();
      chk(tag, obs(), {1'b1, 1'b0, 1'b1, 1'b1, ra7_exp(), 1'b1});
    end
  endtask

  // Cycle a, then optionally cycle b whose request first appears d
  // edges after a's release sample. d<=P makes it pending; d=P+1
  // lands on the edge leaving precharge and starts from IDLE.
  task automatic run_pair(input cyc_t a, input bit two, input cyc_t b,
                          input int d, input string tag);
    int e0a, na, la, s, e0b, nb, lb, last;
    int lat_b;
    bit pend;
    logic ras, mux, c1, c2, wt;
    e0a = cyc + 1;
    na  = e0a + imax(a.hold, need(a));
    la  = na + P + 1;
    s = -100; e0b = -100; nb = -100; lat_b = -100; pend = 1'b0;
    last = la;
    if (two) begin
      s     = na + d;
      pend  = (d <= P);
      e0b   = pend ? la : la + 1;
      lat_b = pend ? s : e0b;
      nb    = e0b + imax(b.hold, need(b));
      lb    = nb + P + 1;
      last  = lb;
    end
    for (int k = e0a; k <= last; k++) begin
      if (k < e0a + a.hold)
        drive_req(a, k == e0a);
      else if (two && k >= s && k < e0b + b.hold)
        drive_req(b, k == lat_b);
      else
        drive_idle();
      step();
      if (!is_mem(a) && k == na) rcount++;
      if (two && !is_mem(b) && k == nb) rcount++;
      ras = !(inr(k, e0a + 1, na) || (two && inr(k, e0b + 1, nb)));
      mux = (is_mem(a) && inr(k, e0a + 2, na)) ||
            (two && is_mem(b) && inr(k, e0b + 2, nb));
      c1  = !(cas_on(a, 2'b01, k, e0a, na) ||
              (two && cas_on(b, 2'b01, k, e0b, nb)));
      c2  = !(cas_on(a, 2'b10, k, e0a, na) ||
              (two && cas_on(b, 2'b10, k, e0b, nb)));
      wt  = !(pend && inr(k, s + 1, la));
      chk(tag, obs(), {ras, mux, c1, c2, ra7_exp(), wt});
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    rcount   = 0;
    RST      = 1'b1;
    drive_idle();
    #2;
    chk("rst_init", obs(), 6'b101101);
    step();
    chk("rst_edge", obs(), 6'b101101);
    RST = 1'b0;
    idle_steps(2, "idle");

    ca = '{0, 2'b01, 5};
    run_pair(ca, 1'b0, ca, 0, "rd_bank1");
    ca = '{1, 2'b10, 3};
    run_pair(ca, 1'b0, ca, 0, "wr_bank2");
    ca = '{2, 2'b01, 4};
    run_pair(ca, 1'b0, ca, 0, "rdwr_bank1");
    ca = '{0, 2'b00, 4};
    run_pair(ca, 1'b0, ca, 0, "rom");
    ca = '{1, 2'b11, 3};
    run_pair(ca, 1'b0, ca, 0, "bank11");
    ca = '{0, 2'b10, 1};
    run_pair(ca, 1'b0, ca, 0, "early_drop");
    ca = '{3, 2'b01, 2};
    run_pair(ca, 1'b0, ca, 0, "refresh");
    idle_steps(1, "idle");

    ca = '{0, 2'b01, 5};
    cb = '{1, 2'b10, 4};
    run_pair(ca, 1'b1, cb, 1, "b2b_d1");
    run_pair(ca, 1'b1, cb, P, "b2b_dlast");
    run_pair(ca, 1'b1, cb, P + 1, "b2b_late");
    cb = '{3, 2'b10, 2};
    run_pair(ca, 1'b1, cb, 1, "b2b_rfsh");

    for (int i = 0; i < 40; i++) begin
      ca = rnd_cyc();
      cb = rnd_cyc();
      run_pair(ca, 1'($urandom), cb, $urandom_range(1, P + 1), "rnd");
      idle_steps($urandom_range(0, 2), "rnd_idle");
    end

    ca = '{$urandom_range(0, 2), 2'b01, 9};
    drive_req(ca, 1'b1);
    step();
    repeat (3) begin
      drive_req(ca, 1'b0);
      step();
    end
    chk("pre_rst_active", obs(), {1'b0, 1'b1, 1'b0, 1'b1, ra7_exp(), 1'b1});
    #2;
    RST = 1'b1;
    #1;
    chk("rst_async", obs(), 6'b101101);
    rcount = 0;
    drive_idle();
    step();
    chk("rst_hold", obs(), 6'b101101);
    RST = 1'b0;
    idle_steps(2, "post_rst");

    for (int i = 1; i <= 2 * ROWS; i++) begin
      ca = '{3, 2'($urandom), $urandom_range(1, 3)};
      run_pair(ca, 1'b0, ca, 0, "rfsh_sweep");
      if (i == ROWS)
        chk("ra7_after_128", {5'b0, RA7}, {5'b0, RA7_ON});
      if (i == 2 * ROWS)
        chk("ra7_after_256", {5'b0, RA7}, 6'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
